// File: rtl/serial2tcp_pkg.sv
// Shared types and constants for the serial2tcp stream loopback block.
package serial2tcp_pkg;

  typedef enum logic [1:0] {
    MODE_LOOPBACK = 2'd0,
    MODE_INVERT   = 2'd1,
    MODE_DRAIN    = 2'd2,
    MODE_GEN      = 2'd3
  } mode_e;

  localparam int unsigned STALL_LIMIT = 255;
  localparam int unsigned STALL_W     = 8;

  // True for the modes in which the source stream is pushed into the FIFO.
  function automatic logic is_stream_mode(input mode_e m);
    return (m == MODE_LOOPBACK) || (m == MODE_INVERT);
  endfunction

endpackage

// File: rtl/serial2tcp_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on pop_data.
module serial2tcp_sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LEVEL_W-1:0] count
);
  import serial2tcp_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LEVEL_W-1:0] count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (count_r == LEVEL_W'(DEPTH));
  assign empty     = (count_r == {LEVEL_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; written only, never reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LEVEL_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + LEVEL_W'(1);
        2'b01:   count_r <= count_r - LEVEL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/serial2tcp_stream_loopback.sv
// Stream loopback with invert/drain/generate modes and stall detection.
// Define SERIAL2TCP_STREAM_LOOPBACK_STATS_EN to add rx_count/tx_count outputs.
module serial2tcp_stream_loopback #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic               serial2tcp_source_valid,
  output logic               serial2tcp_source_ready,
  input  logic [DATA_W-1:0]  serial2tcp_source_data,
  output logic               serial2tcp_sink_valid,
  input  logic               serial2tcp_sink_ready,
  output logic [DATA_W-1:0]  serial2tcp_sink_data,
  output logic [LEVEL_W-1:0] level,
`ifdef SERIAL2TCP_STREAM_LOOPBACK_STATS_EN
  output logic [31:0]        rx_count,
  output logic [31:0]        tx_count,
`endif
  output logic               overflow
);
  import serial2tcp_pkg::*;

  mode_e              mode_s;
  logic               full_s;
  logic               empty_s;
  logic               ready_s;
  logic               push_s;
  logic [DATA_W-1:0]  push_data_s;
  logic               pop_s;
  logic               stall_s;
  logic [DATA_W-1:0]  gen_cnt_r;
  logic [STALL_W-1:0] stall_r;
  logic               overflow_r;

  assign mode_s = mode_e'(mode);

  // Write-side mode mux: selects ready policy and the word pushed this cycle.
  always_comb begin
    ready_s     = 1'b0;
    push_s      = 1'b0;
    push_data_s = {DATA_W{1'b0}};
    case (mode_s)
      MODE_LOOPBACK: begin
        ready_s     = !full_s;
        push_s      = serial2tcp_source_valid && !full_s;
        push_data_s = serial2tcp_source_data;
      end
      MODE_INVERT: begin
        ready_s     = !full_s;
        push_s      = serial2tcp_source_valid && !full_s;
        push_data_s = ~serial2tcp_source_data;
      end
      MODE_DRAIN: begin
        ready_s = 1'b1;
      end
      MODE_GEN: begin
        push_s      = !full_s;
        push_data_s = gen_cnt_r;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Ready is forced low while reset is held, even though the FIFO reads empty.
  assign serial2tcp_source_ready = ready_s & sys_rst_n;
  assign pop_s   = serial2tcp_sink_ready && !empty_s;
  assign stall_s = serial2tcp_source_valid && !serial2tcp_source_ready && is_stream_mode(mode_s);

  serial2tcp_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEVEL_W(LEVEL_W)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .pop_data (serial2tcp_sink_data),
    .full     (full_s),
    .empty    (empty_s),
    .count    (level)
  );

  assign serial2tcp_sink_valid = !empty_s;
  assign overflow              = overflow_r;

  // Pattern counter, stall counter and sticky overflow flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gen_cnt_r  <= {DATA_W{1'b0}};
      stall_r    <= {STALL_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (mode_s == MODE_GEN && !full_s) gen_cnt_r <= gen_cnt_r + DATA_W'(1);
      if (stall_s) begin
        if (stall_r != STALL_W'(STALL_LIMIT)) stall_r <= stall_r + STALL_W'(1);
        if (stall_r == STALL_W'(STALL_LIMIT - 1)) overflow_r <= 1'b1;
      end else begin
        stall_r <= {STALL_W{1'b0}};
      end
    end
  end

`ifdef SERIAL2TCP_STREAM_LOOPBACK_STATS_EN
  // Free-running transfer counters for both stream sides.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_count <= 32'd0;
      tx_count <= 32'd0;
    end else begin
      if (serial2tcp_source_valid && serial2tcp_source_ready) rx_count <= rx_count + 32'd1;
      if (pop_s) tx_count <= tx_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial2tcp_stream_loopback.sv
// Randomised scoreboard bench for serial2tcp_stream_loopback (DATA_W=8, DEPTH=16).
module tb_serial2tcp_stream_loopback;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          sink_ready = 1'b0;
  logic          src_ready;
  logic          sink_valid;
  logic [DW-1:0] sink_data;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef SERIAL2TCP_STREAM_LOOPBACK_STATS_EN
  logic [31:0]   rx_count;
  logic [31:0]   tx_count;
`endif

  serial2tcp_stream_loopback #(.DATA_W(DW), .DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .sys_clk                (sys_clk),
    .sys_rst_n              (sys_rst_n),
    .mode                   (mode),
    .serial2tcp_source_valid(src_valid),
    .serial2tcp_source_ready(src_ready),
    .serial2tcp_source_data (src_data),
    .serial2tcp_sink_valid  (sink_valid),
    .serial2tcp_sink_ready  (sink_ready),
    .serial2tcp_sink_data   (sink_data),
    .level                  (level),
`ifdef SERIAL2TCP_STREAM_LOOPBACK_STATS_EN
    .rx_count               (rx_count),
    .tx_count               (tx_count),
`endif
    .overflow               (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: expected FIFO contents as a queue plus spec-level counters.
  logic [DW-1:0] exp_q[$];
  bit            model_en = 1'b0;
  bit            push_pend = 1'b0;
  bit            gen_pend = 1'b0;
  logic [DW-1:0] push_val = '0;
  bit            stall_pend = 1'b0;
  bit            pop_pend = 1'b0;
  int            gen_model = 0;
  int            gen_total = 0;
  int            consec = 0;
  bit            exp_ovf = 1'b0;
  bit            rand_sink = 1'b0;

  // Write-side model: expected ready, pushed word and stall tracking.
  always @(negedge sys_clk) begin
    if (model_en) begin
      bit er;
      er = 1'b0;
      push_pend = 1'b0;
      gen_pend = 1'b0;
      case (mode)
        2'd0, 2'd1: er = (exp_q.size() != DEPTH);
        2'd2:       er = 1'b1;
        default:    er = 1'b0;
      endcase
      check("source_ready", int'(src_ready), int'(er));
      check("overflow", int'(overflow), int'(exp_ovf));
      if (mode < 2'd2 && src_valid && er) begin
        push_pend = 1'b1;
        push_val = (mode == 2'd1) ? ~src_data : src_data;
      end
      if (mode == 2'd3 && exp_q.size() != DEPTH) begin
        push_pend = 1'b1;
        gen_pend = 1'b1;
        push_val = DW'(gen_model);
      end
      stall_pend = src_valid && !er && (mode < 2'd2);
    end
  end

  always @(posedge sys_clk) begin
    if (model_en) begin
      if (push_pend) exp_q.push_back(push_val);
      if (gen_pend) begin
        gen_model = (gen_model + 1) % 256;
        gen_total++;
      end
      push_pend = 1'b0;
      gen_pend = 1'b0;
      consec = stall_pend ? consec + 1 : 0;
      if (consec >= 255) exp_ovf = 1'b1;
    end
  end

  // Monitor: compares the sink side against the head of the expected queue.
  always @(negedge sys_clk) begin
    if (model_en) begin
      check("sink_valid", int'(sink_valid), int'(exp_q.size() != 0));
      check("level", int'(level), exp_q.size());
      if (exp_q.size() != 0) check("sink_data", int'(sink_data), int'(exp_q[0]));
      pop_pend = (exp_q.size() != 0) && sink_ready;
    end
  end

  always @(posedge sys_clk) begin
    if (model_en && pop_pend) begin
      void'(exp_q.pop_front());
      pop_pend = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (rand_sink) sink_ready = ($urandom % 2) == 1;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    src_valid = 1'b1;
    src_data = d;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!src_ready && n < 2000);
    check("send_accepted", int'(src_ready), 1);
    @(posedge sys_clk);
    #1;
    src_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_ready", int'(src_ready), 0);
    check("rst_sink_valid", int'(sink_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_en = 1'b1;

    // In-order loopback with an always-ready sink.
    mode = 2'd0;
    sink_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(DW'(i));
    wait_idle();

    // Fill under backpressure, stall, then release.
    sink_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'($urandom));
    src_valid = 1'b1;
    src_data = DW'($urandom);
    repeat (5) @(posedge sys_clk);
    #1;
    check("full_level", int'(level), 16);
    sink_ready = 1'b1;
    send(src_data);
    for (int i = 0; i < 3; i++) send(DW'($urandom));
    wait_idle();

    // Invert mode.
    mode = 2'd1;
    send(8'hA5);
    send(8'h00);
    wait_idle();

    // Mixed loopback/invert traffic with a random sink.
    rand_sink = 1'b1;
    for (int i = 0; i < 150; i++) begin
      mode = 2'($urandom % 2);
      repeat ($urandom % 3) @(posedge sys_clk);
      #1;
      send(DW'($urandom));
    end
    rand_sink = 1'b0;
    sink_ready = 1'b1;
    wait_idle();

    // Drain discards new words while buffered ones still leave.
    sink_ready = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 3; i++) send(DW'($urandom));
    mode = 2'd2;
    for (int i = 0; i < 10; i++) send(DW'($urandom));
    check("drain_level", int'(level), 3);
    sink_ready = 1'b1;
    wait_idle();

    // Pattern generation through the 8-bit wrap.
    mode = 2'd3;
    rand_sink = 1'b1;
    for (int n = 0; n < 3000 && gen_total < 270; n++) @(posedge sys_clk);
    #1;
    mode = 2'd2;
    rand_sink = 1'b0;
    sink_ready = 1'b1;
    check("gen_wrapped", int'(gen_total >= 257), 1);
    wait_idle();

    // Long stall on a full FIFO sets the sticky overflow.
    mode = 2'd0;
    sink_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'($urandom));
    src_valid = 1'b1;
    src_data = DW'($urandom);
    repeat (300) @(posedge sys_clk);
    #1;
    check("overflow_set", int'(overflow), 1);

    // Asynchronous reset in the middle of streaming.
    sink_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2;
    model_en = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("arst_ready", int'(src_ready), 0);
    check("arst_sink_valid", int'(sink_valid), 0);
    check("arst_level", int'(level), 0);
    check("arst_overflow", int'(overflow), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
